// File: rtl/r_prog_pkg.sv
// Shared types and constants for the r_prog resistor-trim sequencer.
package r_prog_pkg;

  localparam logic [7:0] R_CTR_OFF  = 8'hFF;
  localparam logic [4:0] R_PROG_MAX = 5'd15;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_IDLE,
    ST_SETTLE
  } r_prog_state_t;

  // One code step toward the target; the caller only steps when cur != tgt.
  function automatic logic [4:0] step_toward(input logic [4:0] cur, input logic [4:0] tgt);
    return (tgt > cur) ? cur + 5'd1 : cur - 5'd1;
  endfunction

endpackage

// File: rtl/resistors_decoder.sv
// Combinational map from resistor-trim code to the 8-bit switch word.
module resistors_decoder
  import r_prog_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] r_ctr
);

  always_comb begin
    r_ctr = R_CTR_OFF;
    case (code)
      5'd0:    r_ctr = 8'hEE;
      5'd1:    r_ctr = 8'h5E;
      5'd2:    r_ctr = 8'hDE;
      5'd3:    r_ctr = 8'hBE;
      5'd4:    r_ctr = 8'hE5;
      5'd5:    r_ctr = 8'h55;
      5'd6:    r_ctr = 8'hD5;
      5'd7:    r_ctr = 8'hB5;
      5'd8:    r_ctr = 8'hED;
      5'd9:    r_ctr = 8'h5D;
      5'd10:   r_ctr = 8'hDD;
      5'd11:   r_ctr = 8'hBD;
      5'd12:   r_ctr = 8'hEB;
      5'd13:   r_ctr = 8'h5B;
      5'd14:   r_ctr = 8'hDB;
      5'd15:   r_ctr = 8'hBB;
      default: r_ctr = R_CTR_OFF;
    endcase
  end

endmodule

// File: rtl/r_prog_ramp_ctrl.sv
// Resistor-trim sequencer: ramps r_prog one code per settle interval toward a
// requested target and drives the registered switch word R_ctr.
module r_prog_ramp_ctrl
  import r_prog_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [4:0] req_code,
  output logic       req_ready,
  input  logic       force_off,
  output logic [4:0] r_prog,
  output logic [7:0] R_ctr,
  output logic       on,
  output logic       busy,
  output logic       done
);

  localparam int unsigned     CW     = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]   RELOAD = CW'(SETTLE_CYCLES - 1);

  r_prog_state_t state_q, state_d;
  logic [4:0]    code_d;
  logic [4:0]    target_q, target_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_d;
  logic          accept;
  logic [7:0]    r_ctr_dec;
  logic [7:0]    r_ctr_d;

  assign req_ready = (state_q != ST_SETTLE) && !force_off;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q == ST_SETTLE);
  assign on        = (R_ctr != R_CTR_OFF);

  always_comb begin
    state_d  = state_q;
    code_d   = r_prog;
    target_d = target_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (force_off) begin
      state_d  = ST_OFF;
      cnt_d    = '0;
      target_d = r_prog;
    end else if (accept) begin
      if (req_code > R_PROG_MAX) begin
        state_d = ST_OFF;
        done_d  = 1'b1;
      end else if (state_q == ST_OFF) begin
        code_d   = req_code;
        target_d = req_code;
        cnt_d    = RELOAD;
        state_d  = ST_SETTLE;
      end else if (req_code == r_prog) begin
        done_d = 1'b1;
      end else begin
        target_d = req_code;
        code_d   = step_toward(r_prog, req_code);
        cnt_d    = RELOAD;
        state_d  = ST_SETTLE;
      end
    end else if (state_q == ST_SETTLE) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (r_prog != target_q) begin
        code_d = step_toward(r_prog, target_q);
        cnt_d  = RELOAD;
      end else begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  // Decoder sees the next-state code so R_ctr and r_prog update on the same edge.
  resistors_decoder u_dec (
    .code  (code_d),
    .r_ctr (r_ctr_dec)
  );

  assign r_ctr_d = (state_d == ST_OFF) ? R_CTR_OFF : r_ctr_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      r_prog   <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      R_ctr    <= R_CTR_OFF;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_prog   <= code_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      R_ctr    <= r_ctr_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_r_prog_ramp_ctrl.sv
// Scoreboard bench for r_prog_ramp_ctrl: stimulus queues expected output events,
// a monitor pops one whenever R_ctr changes or done pulses.
module tb_r_prog_ramp_ctrl;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [4:0] req_code;
  logic       req_ready;
  logic       force_off;
  logic [4:0] r_prog;
  logic [7:0] R_ctr;
  logic       on;
  logic       busy;
  logic       done;

  r_prog_ramp_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .force_off (force_off),
    .r_prog    (r_prog),
    .R_ctr     (R_ctr),
    .on        (on),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] rc;
    logic [4:0] rp;
    logic       on;
    logic       busy;
    logic       done;
    bit         chk_rp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic [7:0] dec_tab [16] = '{8'hEE, 8'h5E, 8'hDE, 8'hBE, 8'hE5, 8'h55, 8'hD5, 8'hB5,
                               8'hED, 8'h5D, 8'hDD, 8'hBD, 8'hEB, 8'h5B, 8'hDB, 8'hBB};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int c, input logic [7:0] rc, input int rp, input logic o,
                          input logic b, input logic d, input bit chk_rp = 1'b1);
    exp_t e;
    e.cyc = c; e.rc = rc; e.rp = 5'(rp); e.on = o; e.busy = b; e.done = d; e.chk_rp = chk_rp;
    q.push_back(e);
  endtask

  // Expected schedule of a ramp from an IDLE code: step k at T+1+(k-1)*S, done at T+1+N*S.
  task automatic push_ramp(input int t, input int from, input int to);
    int n;
    int code;
    n = (to > from) ? to - from : from - to;
    for (int k = 1; k <= n; k++) begin
      code = (to > from) ? from + k : from - k;
      push_exp(t + 1 + (k - 1) * S, dec_tab[code], code, 1'b1, 1'b1, 1'b0);
    end
    push_exp(t + 1 + n * S, dec_tab[to], to, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic send(input logic [4:0] c);
    req_code  = c;
    req_valid = 1'b1;
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d expected events still pending at cycle %0d, want 0", q.size(), cyc);
      q.delete();
    end
  endtask

  // Monitor
  initial begin
    logic [7:0] prev;
    exp_t       e;
    prev = 8'hFF;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev = R_ctr;
        continue;
      end
      if (R_ctr !== prev || done === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: cycle %0d R_ctr=%h r_prog=%0d done=%b, want no event",
                   cyc, R_ctr, r_prog, done);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc || R_ctr !== e.rc || on !== e.on || busy !== e.busy ||
              done !== e.done || (e.chk_rp && r_prog !== e.rp)) begin
            fails++;
            $display("FAIL event: got cyc=%0d R_ctr=%h r_prog=%0d on=%b busy=%b done=%b, want cyc=%0d R_ctr=%h r_prog=%0d on=%b busy=%b done=%b",
                     cyc, R_ctr, r_prog, on, busy, done, e.cyc, e.rc, e.rp, e.on, e.busy, e.done);
          end
        end
      end
      prev = R_ctr;
    end
  end

  initial begin
    int  t;
    logic bad;
    rst_n = 1'b1; req_valid = 1'b0; req_code = '0; force_off = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("reset_R_ctr", 32'(R_ctr), 32'hFF);
    chk("reset_on", 32'(on), 0);
    chk("reset_ready", 32'(req_ready), 1);
    chk("reset_r_prog", 32'(r_prog), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);

    // Code 0 from OFF: no ramp, done after S.
    t = cyc;
    push_exp(t + 1, 8'hEE, 0, 1'b1, 1'b1, 1'b0);
    push_exp(t + 5, 8'hEE, 0, 1'b1, 1'b0, 1'b1);
    send(5'd0);
    chk("ready_low_after_off_accept", 32'(req_ready), 0);
    wait_drain();

    // 0 -> 3 with a competing request held during settle; it must be ignored.
    t = cyc;
    push_exp(t + 1,  8'h5E, 1, 1'b1, 1'b1, 1'b0);
    push_exp(t + 5,  8'hDE, 2, 1'b1, 1'b1, 1'b0);
    push_exp(t + 9,  8'hBE, 3, 1'b1, 1'b1, 1'b0);
    push_exp(t + 13, 8'hBE, 3, 1'b1, 1'b0, 1'b1);
    send(5'd3);
    req_code = 5'd9; req_valid = 1'b1;
    bad = 1'b0;
    while (cyc < t + 12) begin
      if (req_ready !== 1'b0) bad = 1'b1;
      @(negedge clk); #1;
    end
    if (req_ready !== 1'b0) bad = 1'b1;
    req_valid = 1'b0;
    chk("ready_low_in_settle", 32'(bad), 0);
    wait_drain();

    // Long ascending ramp to the top code, then descend to 13.
    t = cyc; push_ramp(t, 3, 15); send(5'd15); wait_drain();
    chk("top_R_ctr", 32'(R_ctr), 32'hBB);
    t = cyc;
    push_exp(t + 1, 8'hDB, 14, 1'b1, 1'b1, 1'b0);
    push_exp(t + 5, 8'h5B, 13, 1'b1, 1'b1, 1'b0);
    push_exp(t + 9, 8'h5B, 13, 1'b1, 1'b0, 1'b1);
    send(5'd13);
    wait_drain();

    // force_off mid-ramp together with a request: OFF, no done.
    t = cyc;
    push_exp(t + 1, 8'hEB, 12, 1'b1, 1'b1, 1'b0);
    send(5'd9);
    force_off = 1'b1; req_valid = 1'b1; req_code = 5'd2;
    #1 chk("ready_low_force_off", 32'(req_ready), 0);
    push_exp(t + 2, 8'hFF, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    force_off = 1'b0; req_valid = 1'b0;
    wait_drain();
    repeat (2 * S) @(negedge clk);
    #1 chk("ready_after_force_off", 32'(req_ready), 1);
    t = cyc;
    push_exp(t + 1, 8'h55, 5, 1'b1, 1'b1, 1'b0);
    push_exp(t + 5, 8'h55, 5, 1'b1, 1'b0, 1'b1);
    send(5'd5);
    wait_drain();

    // 5 -> 7, OFF via code 20, OFF again via code 16, back on at 7, same-code request.
    t = cyc; push_ramp(t, 5, 7); send(5'd7); wait_drain();
    t = cyc; push_exp(t + 1, 8'hFF, 7, 1'b0, 1'b0, 1'b1); send(5'd20); wait_drain();
    t = cyc; push_exp(t + 1, 8'hFF, 7, 1'b0, 1'b0, 1'b1); send(5'd16); wait_drain();
    t = cyc;
    push_exp(t + 1, 8'hB5, 7, 1'b1, 1'b1, 1'b0);
    push_exp(t + 5, 8'hB5, 7, 1'b1, 1'b0, 1'b1);
    send(5'd7);
    wait_drain();
    t = cyc; push_exp(t + 1, 8'hB5, 7, 1'b1, 1'b0, 1'b1); send(5'd7); wait_drain();

    // Asynchronous reset mid-ramp, between clock edges.
    t = cyc;
    push_exp(t + 1, 8'hD5, 6, 1'b1, 1'b1, 1'b0);
    send(5'd0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_R_ctr", 32'(R_ctr), 32'hFF);
    chk("async_rst_r_prog", 32'(r_prog), 0);
    chk("async_rst_on", 32'(on), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_ready", 32'(req_ready), 1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    t = cyc;
    push_exp(t + 1, 8'hDE, 2, 1'b1, 1'b1, 1'b0);
    push_exp(t + 5, 8'hDE, 2, 1'b1, 1'b0, 1'b1);
    send(5'd2);
    wait_drain();
    repeat (4) @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
